// File: rtl/ps2_mouse_packetizer_if.sv
// ps2_mouse_packetizer_if: byte-level PS/2 link plus decoded mouse packet outputs.
// Ports: rx_data/rx_done_tick from the receiver; tx_idle/tx_done_tick from the
// transmitter; wr_ps2/tx_data to the transmitter; x/y/btn/m_done_tick/init_done
// to the display logic. slave = packetizer side, master = environment side.
interface ps2_mouse_packetizer_if;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       wr_ps2;
  logic [7:0] tx_data;
  logic [8:0] x;
  logic [8:0] y;
  logic [2:0] btn;
  logic       m_done_tick;
  logic       init_done;
  modport slave(
    input  rx_data, rx_done_tick, tx_idle, tx_done_tick,
    output wr_ps2, tx_data, x, y, btn, m_done_tick, init_done
  );
  modport master(
    output rx_data, rx_done_tick, tx_idle, tx_done_tick,
    input  wr_ps2, tx_data, x, y, btn, m_done_tick, init_done
  );
endinterface

// File: rtl/ps2_mouse_packetizer.sv
// ps2_mouse_packetizer: enables PS/2 mouse streaming, then turns 3-byte packets into x/y/btn.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries the receiver/transmitter
// handshake in and the decoded deltas, buttons, m_done_tick and init_done out.
module ps2_mouse_packetizer #(
  parameter int         TIMEOUT_CYC = 2000000,
  parameter logic [7:0] INIT_CMD    = 8'hF4,
  parameter logic [7:0] ACK_BYTE    = 8'hFA
) (
  input logic                    clk,
  input logic                    rst_n,
  ps2_mouse_packetizer_if.slave  bus
);
  localparam int TW = TIMEOUT_CYC > 2 ? $clog2(TIMEOUT_CYC) : 1;
  typedef enum logic [2:0] {SEND, WAIT_TX, WAIT_ACK, B0, B1, B2, DONE} state_t;
  state_t          r_state, w_next;
  logic [TW-1:0]   r_timer, w_timer;
  logic [6:0]      r_b0;
  logic [7:0]      r_bx;
  logic [8:0]      r_x, r_y;
  logic [2:0]      r_btn;
  logic            r_wr, r_done, r_init;
  logic [7:0]      r_tx_data;
  logic            w_rx, w_to, w_timed;
  // A plain 9-bit join of sign and 0x00 would give -256; it is folded into -255
  // alongside saturation so consumers can take 1+~d[7:0] without an 8-bit wrap.
  function automatic logic [8:0] delta(input logic ovf, input logic sgn, input logic [7:0] b);
    return ovf ? (sgn ? 9'h101 : 9'h0FF) : (sgn && b == 8'h00) ? 9'h101 : {sgn, b};
  endfunction
  assign w_rx    = bus.rx_done_tick;
  assign w_to    = r_timer == TW'(TIMEOUT_CYC - 1);
  assign w_timed = r_state inside {WAIT_ACK, B1, B2};
  always_comb begin
    w_next = r_state;
    case (r_state)
      SEND:     w_next = bus.tx_idle ? WAIT_TX : SEND;
      WAIT_TX:  w_next = bus.tx_done_tick ? WAIT_ACK : WAIT_TX;
      WAIT_ACK: w_next = (w_rx && bus.rx_data == ACK_BYTE) ? B0 : w_to ? SEND : WAIT_ACK;
      B0:       w_next = (w_rx && bus.rx_data[3]) ? B1 : B0;
      B1:       w_next = w_rx ? B2 : w_to ? B0 : B1;
      B2:       w_next = w_rx ? DONE : w_to ? B0 : B2;
      default:  w_next = B0;
    endcase
  end
  // Every state change restarts the timer; it only runs while dwelling in a timed state.
  assign w_timer = (w_timed && w_next == r_state) ? r_timer + 1'b1 : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= SEND;
      r_timer   <= '0;
      r_b0      <= '0;
      r_bx      <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_btn     <= '0;
      r_wr      <= 1'b0;
      r_done    <= 1'b0;
      r_init    <= 1'b0;
      r_tx_data <= INIT_CMD;
    end else begin
      r_state   <= w_next;
      r_timer   <= w_timer;
      r_tx_data <= INIT_CMD;
      r_wr      <= r_state == SEND && bus.tx_idle;
      r_done    <= r_state == B2 && w_rx;
      if (r_state == WAIT_ACK && w_next == B0) r_init <= 1'b1;
      // Bit 3 is always 1 in an accepted header, so it is not kept.
      if (r_state == B0 && w_next == B1) r_b0 <= {bus.rx_data[7:4], bus.rx_data[2:0]};
      if (r_state == B1 && w_rx) r_bx <= bus.rx_data;
      if (r_state == B2 && w_rx) begin
        r_x   <= delta(r_b0[5], r_b0[3], r_bx);
        r_y   <= delta(r_b0[6], r_b0[4], bus.rx_data);
        r_btn <= r_b0[2:0];
      end
    end
  end
  assign bus.wr_ps2      = r_wr;
  assign bus.tx_data     = r_tx_data;
  assign bus.x           = r_x;
  assign bus.y           = r_y;
  assign bus.btn         = r_btn;
  assign bus.m_done_tick = r_done;
  assign bus.init_done   = r_init;
endmodule

// File: tb/tb_ps2_mouse_packetizer.sv
// tb_ps2_mouse_packetizer: directed stimulus with a queue-based scoreboard and a negedge monitor.
module tb_ps2_mouse_packetizer;
  localparam int T = 40;
  typedef struct {logic [8:0] x; logic [8:0] y; logic [2:0] btn; int cyc;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ps2_mouse_packetizer_if bus();
  ps2_mouse_packetizer #(.TIMEOUT_CYC(T), .INIT_CMD(8'hF4), .ACK_BYTE(8'hFA)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  exp_t       sb[$];
  logic [7:0] txq[$];
  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int n_wr = 0;
  int n_tick = 0;
  int exp_tick = 0;
  int exp_wr = 0;
  logic prev_tick = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] t;
    ncyc++;
    if (bus.m_done_tick) begin
      n_tick++;
      chk("tick_not_consecutive", 32'(prev_tick), 32'd0);
      if (sb.size() == 0) chk("unexpected_tick", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("pkt_x", 32'(bus.x), 32'(e.x));
        chk("pkt_y", 32'(bus.y), 32'(e.y));
        chk("pkt_btn", 32'(bus.btn), 32'(e.btn));
        chk("pkt_latency", 32'(ncyc), 32'(e.cyc));
      end
    end
    prev_tick = bus.m_done_tick;
    if (bus.wr_ps2) begin
      n_wr++;
      if (txq.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
      else begin
        t = txq.pop_front();
        chk("tx_data", 32'(bus.tx_data), 32'(t));
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done_tick = 1'b1;
    cyc(1);
    bus.rx_done_tick = 1'b0;
    cyc(3);
  endtask
  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [8:0] ex, input logic [8:0] ey, input logic [2:0] eb);
    exp_t e;
    send_byte(b0);
    send_byte(b1);
    e.x = ex;
    e.y = ey;
    e.btn = eb;
    e.cyc = ncyc + 2;
    sb.push_back(e);
    exp_tick++;
    send_byte(b2);
  endtask
  task automatic tx_done();
    bus.tx_done_tick = 1'b1;
    cyc(1);
    bus.tx_done_tick = 1'b0;
    cyc(1);
  endtask
  task automatic check_reset_outputs();
    chk("rst_x", 32'(bus.x), 32'd0);
    chk("rst_y", 32'(bus.y), 32'd0);
    chk("rst_btn", 32'(bus.btn), 32'd0);
    chk("rst_tick", 32'(bus.m_done_tick), 32'd0);
    chk("rst_wr", 32'(bus.wr_ps2), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'hF4);
    chk("rst_init_done", 32'(bus.init_done), 32'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within bound");
    $fatal(1);
  end
  initial begin
    bus.rx_data = 8'h00;
    bus.rx_done_tick = 1'b0;
    bus.tx_idle = 1'b0;
    bus.tx_done_tick = 1'b0;
    cyc(3);
    check_reset_outputs();
    rst_n = 1'b1;
    cyc(4);
    chk("send_waits_idle", 32'(n_wr), 32'd0);
    txq.push_back(8'hF4);
    exp_wr++;
    bus.tx_idle = 1'b1;
    cyc(4);
    chk("first_wr_once", 32'(n_wr), 32'(exp_wr));
    send_byte(8'hFA);
    chk("rx_ignored_wait_tx", 32'(bus.init_done), 32'd0);
    tx_done();
    send_byte(8'hFE);
    chk("non_ack_ignored", 32'(bus.init_done), 32'd0);
    chk("no_early_retry", 32'(n_wr), 32'(exp_wr));
    txq.push_back(8'hF4);
    exp_wr++;
    cyc(T + 2);
    chk("ack_timeout_retry", 32'(n_wr), 32'(exp_wr));
    chk("retry_init_low", 32'(bus.init_done), 32'd0);
    tx_done();
    send_byte(8'hFA);
    chk("init_done", 32'(bus.init_done), 32'd1);
    send_pkt(8'h09, 8'h05, 8'hFE, 9'h005, 9'h0FE, 3'b001);
    send_pkt(8'h38, 8'h10, 8'hF0, 9'h110, 9'h1F0, 3'b000);
    send_byte(8'h01);
    send_pkt(8'h08, 8'h00, 8'h00, 9'h000, 9'h000, 3'b000);
    send_byte(8'h08);
    send_byte(8'h03);
    cyc(T + 2);
    send_pkt(8'h0A, 8'h01, 8'h02, 9'h001, 9'h002, 3'b010);
    send_pkt(8'h58, 8'h7F, 8'h22, 9'h101, 9'h022, 3'b000);
    send_pkt(8'h88, 8'h12, 8'h34, 9'h012, 9'h0FF, 3'b000);
    send_pkt(8'h1F, 8'h00, 8'h80, 9'h101, 9'h080, 3'b111);
    cyc(5);
    chk("outputs_hold", 32'({bus.x, bus.y, bus.btn}), 32'({9'h101, 9'h080, 3'b111}));
    send_byte(8'h08);
    send_byte(8'h01);
    bus.tx_idle = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk("post_reset_send_waits", 32'(n_wr), 32'(exp_wr));
    txq.push_back(8'hF4);
    exp_wr++;
    bus.tx_idle = 1'b1;
    cyc(4);
    chk("post_reset_wr", 32'(n_wr), 32'(exp_wr));
    send_byte(8'h02);
    cyc(5);
    chk("tick_count", 32'(n_tick), 32'(exp_tick));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("txq_empty", 32'(txq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
